interleave_settle_checker: RTL and testbench

INTERLEAVE_SETTLE_CHECKER -- requirements
Module: interleave_settle_checker

---
 rtl/interleave_pkg.sv | 32 +++
 rtl/interleave_settle_checker_rec_fifo.sv | 79 +++++++
 rtl/interleave_settle_checker.sv | 125 ++++++++++++
 tb/tb_interleave_settle_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interleave_pkg.sv
// Shared types and helpers for the interleave settle checker: FSM states,
// mismatch record layout and the alternating expected-pattern generator.
package interleave_pkg;

  localparam int unsigned V_W   = 10;
  localparam int unsigned N_W   = 4;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLING,
    ST_PASS,
    ST_FAIL
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [V_W-1:0]   v;
    logic [N_W-1:0]   n;
  } rec_t;

  // Bit k follows stim for even k and its inverse for odd k; bits >= width are zero.
  function automatic logic [V_W-1:0] exp_pattern(input logic stim, input int unsigned width);
    logic [V_W-1:0] pat;
    pat = '0;
    for (int unsigned k = 0; k < V_W; k++) begin
      if (k < width) pat[k] = stim ^ k[0];
    end
    return pat;
  endfunction

endpackage

// File: rtl/interleave_settle_checker_rec_fifo.sv
// Synchronous mismatch-record FIFO with flush and a sticky drop flag.
module rec_fifo
  import interleave_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic valid,
  output T     head,
  output logic overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop, full;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    full    = (cnt_q == FULL_CNT);
    do_pop  = pop && (cnt_q != '0);
    // A pop frees the head slot in the same edge, so a full FIFO still accepts the push.
    do_push = push && (!full || do_pop);
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      if (push && !do_push) ovf_d = 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign valid    = (cnt_q != '0);
  assign head     = valid ? mem_q[rd_q] : '0;
  assign overflow = ovf_q;

endmodule

// File: rtl/interleave_settle_checker.sv
// Arms on start, waits for the fan-out bits to settle to the alternating
// pattern of the latched stimulus, and logs every mismatching cycle.
module interleave_settle_checker
  import interleave_pkg::*;
#(
  parameter int unsigned SETTLE_MAX = 8,
  parameter int unsigned REC_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stim,
  input  logic [9:0]  v_obs,
  input  logic [3:0]  n_obs,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  settle_cycles,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [17:0] rec_data,
  output logic        overflow
);

  state_t           state_q, state_d;
  logic             stim_q, stim_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [IDX_W-1:0] settle_q, settle_d;
  logic             flush, push, match;
  logic [V_W-1:0]   v_pat, n_pat;
  rec_t             push_rec, head_rec;

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    settle_d = settle_q;
    flush    = 1'b0;
    push     = 1'b0;
    v_pat    = exp_pattern(stim_q, V_W);
    n_pat    = exp_pattern(stim_q, N_W);
    match    = (v_obs == v_pat) && ({{(V_W-N_W){1'b0}}, n_obs} == n_pat);
    push_rec.idx = idx_q;
    push_rec.v   = v_obs;
    push_rec.n   = n_obs;
    case (state_q)
      ST_SETTLING: begin
        if (match) begin
          state_d  = ST_PASS;
          done_d   = 1'b1;
          pass_d   = 1'b1;
          busy_d   = 1'b0;
          settle_d = idx_q;
        end else begin
          push = 1'b1;
          if (idx_q == IDX_W'(SETTLE_MAX - 1)) begin
            state_d  = ST_FAIL;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            settle_d = IDX_W'(SETTLE_MAX);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          state_d  = ST_SETTLING;
          stim_d   = stim;
          idx_d    = '0;
          flush    = 1'b1;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          settle_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      stim_q   <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      settle_q <= settle_d;
    end
  end

  rec_fifo #(
    .DEPTH (REC_DEPTH),
    .T     (rec_t)
  ) u_rec_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_rec),
    .pop       (rec_ready),
    .valid     (rec_valid),
    .head      (head_rec),
    .overflow  (overflow)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign settle_cycles = settle_q;
  assign rec_data      = head_rec;

endmodule

// File: tb/tb_interleave_settle_checker.sv
// Bench for interleave_settle_checker: directed table, corner-case sequences
// and random traffic checked against a queue-based reference model.
module tb_interleave_settle_checker;

  localparam int SMAX  = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, start, stim, rec_ready;
  logic [9:0]  v_obs;
  logic [3:0]  n_obs;
  logic        busy, done, pass, rec_valid, overflow;
  logic [3:0]  settle_cycles;
  logic [17:0] rec_data;

  int n_cmp = 0;
  int n_err = 0;

  int          m_phase;
  logic        m_stim;
  int          m_idx;
  logic [17:0] m_q[$];
  logic        m_ovf, m_done, m_pass, m_busy;
  int          m_settle;

  typedef struct {
    logic        rst, start, stim;
    logic [9:0]  v;
    logic [3:0]  n;
    logic        ready;
    logic        busy, done, pass;
    logic [3:0]  settle;
    logic        valid;
    logic [17:0] data;
    logic        ovf;
  } vec_t;

  vec_t tbl[13];

  interleave_settle_checker #(
    .SETTLE_MAX (SMAX),
    .REC_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stim          (stim),
    .v_obs         (v_obs),
    .n_obs         (n_obs),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .settle_cycles (settle_cycles),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_data      (rec_data),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, s, st, input logic [9:0] v, input logic [3:0] n,
                              input logic rdy, input logic eb, ed, ep, input logic [3:0] es,
                              input logic ev, input logic [17:0] edata, input logic eo);
    vec_t t;
    t.rst = r; t.start = s; t.stim = st; t.v = v; t.n = n; t.ready = rdy;
    t.busy = eb; t.done = ed; t.pass = ep; t.settle = es; t.valid = ev; t.data = edata; t.ovf = eo;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: pattern constants, a queue for the record FIFO, plain counters.
  task automatic model_step();
    logic        pop;
    logic [9:0]  ve;
    logic [3:0]  ne;
    logic [17:0] rec;
    if (rst) begin
      m_phase = 0; m_stim = 1'b0; m_idx = 0; m_q.delete();
      m_ovf = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_busy = 1'b0; m_settle = 0;
      return;
    end
    pop    = rec_ready && (m_q.size() > 0);
    m_done = 1'b0;
    if (m_phase != 1 && start) begin
      m_phase = 1; m_stim = stim; m_idx = 0; m_q.delete();
      m_ovf = 1'b0; m_pass = 1'b0; m_busy = 1'b1; m_settle = 0;
      return;
    end
    if (pop) void'(m_q.pop_front());
    if (m_phase == 1) begin
      ve = m_stim ? 10'h155 : 10'h2AA;
      ne = m_stim ? 4'h5 : 4'hA;
      if (v_obs == ve && n_obs == ne) begin
        m_phase = 2; m_done = 1'b1; m_pass = 1'b1; m_busy = 1'b0; m_settle = m_idx;
      end else begin
        rec = {m_idx[3:0], v_obs, n_obs};
        if (m_q.size() < DEPTH) m_q.push_back(rec);
        else m_ovf = 1'b1;
        if (m_idx == SMAX - 1) begin
          m_phase = 3; m_done = 1'b1; m_busy = 1'b0; m_settle = SMAX;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".busy"},   busy,          m_busy);
    chk({tag, ".done"},   done,          m_done);
    chk({tag, ".pass"},   pass,          m_pass);
    chk({tag, ".settle"}, settle_cycles, m_settle);
    chk({tag, ".valid"},  rec_valid,     m_q.size() > 0);
    chk({tag, ".data"},   rec_data,      (m_q.size() > 0) ? m_q[0] : 18'd0);
    chk({tag, ".ovf"},    overflow,      m_ovf);
  endtask

  task automatic cyc(input string tag, input logic r, s, st, input logic [9:0] v,
                     input logic [3:0] n, input logic rdy);
    rst = r; start = s; stim = st; v_obs = v; n_obs = n; rec_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stim = 1'b0; v_obs = '0; n_obs = '0; rec_ready = 1'b0;

    tbl[0]  = mk(1, 0, 0, 10'h000, 4'h0, 0,  0, 0, 0, 4'd0, 0, 18'h00000, 0);
    tbl[1]  = mk(0, 1, 1, 10'h155, 4'h5, 0,  1, 0, 0, 4'd0, 0, 18'h00000, 0);
    tbl[2]  = mk(0, 0, 0, 10'h155, 4'h5, 0,  0, 1, 1, 4'd0, 0, 18'h00000, 0);
    tbl[3]  = mk(0, 0, 0, 10'h000, 4'h0, 0,  0, 0, 1, 4'd0, 0, 18'h00000, 0);
    tbl[4]  = mk(0, 1, 1, 10'h2AA, 4'h0, 0,  1, 0, 0, 4'd0, 0, 18'h00000, 0);
    tbl[5]  = mk(0, 0, 0, 10'h2AA, 4'h0, 0,  1, 0, 0, 4'd0, 1, 18'h02AA0, 0);
    tbl[6]  = mk(0, 0, 0, 10'h2AA, 4'h0, 0,  1, 0, 0, 4'd0, 1, 18'h02AA0, 0);
    tbl[7]  = mk(0, 0, 0, 10'h2AA, 4'h0, 0,  1, 0, 0, 4'd0, 1, 18'h02AA0, 0);
    tbl[8]  = mk(0, 0, 0, 10'h155, 4'h5, 0,  0, 1, 1, 4'd3, 1, 18'h02AA0, 0);
    tbl[9]  = mk(0, 0, 0, 10'h000, 4'h0, 1,  0, 0, 1, 4'd3, 1, 18'h06AA0, 0);
    tbl[10] = mk(0, 0, 0, 10'h000, 4'h0, 1,  0, 0, 1, 4'd3, 1, 18'h0AAA0, 0);
    tbl[11] = mk(0, 0, 0, 10'h000, 4'h0, 1,  0, 0, 1, 4'd3, 0, 18'h00000, 0);
    tbl[12] = mk(0, 0, 0, 10'h000, 4'h0, 0,  0, 0, 1, 4'd3, 0, 18'h00000, 0);

    // Directed table: instant pass, then late settle with drain.
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; stim = tbl[i].stim;
      v_obs = tbl[i].v; n_obs = tbl[i].n; rec_ready = tbl[i].ready;
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.busy", i),   busy,          tbl[i].busy);
      chk($sformatf("tbl%0d.done", i),   done,          tbl[i].done);
      chk($sformatf("tbl%0d.pass", i),   pass,          tbl[i].pass);
      chk($sformatf("tbl%0d.settle", i), settle_cycles, tbl[i].settle);
      chk($sformatf("tbl%0d.valid", i),  rec_valid,     tbl[i].valid);
      chk($sformatf("tbl%0d.data", i),   rec_data,      tbl[i].data);
      chk($sformatf("tbl%0d.ovf", i),    overflow,      tbl[i].ovf);
    end

    // Timeout with no consumer: records 0..3 kept, later ones dropped.
    cyc("to", 0, 1, 0, 10'h000, 4'h0, 0);
    for (int i = 0; i < SMAX; i++) cyc("to", 0, 0, 0, 10'h000, 4'h0, 0);
    chk("to.settle8", settle_cycles, 32'd8);
    chk("to.ovf1",    overflow,      32'd1);
    chk("to.pass0",   pass,          32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("to.idx%0d", i), rec_data[17:14], i);
      cyc("to.drain", 0, 0, 0, 10'h000, 4'h0, 1);
    end
    chk("to.empty", rec_valid, 32'd0);

    // Backpressure: fill, then push+pop while full, stall in PASS, drain in order.
    cyc("bp", 0, 1, 1, 10'h000, 4'h0, 0);
    chk("bp.ovf_clr", overflow, 32'd0);
    for (int i = 0; i < 4; i++) cyc("bp.fill", 0, 0, 0, 10'h3FF, 4'hF, 0);
    cyc("bp.pp", 0, 0, 0, 10'h3FF, 4'hF, 1);
    cyc("bp.pp", 0, 0, 0, 10'h3FF, 4'hF, 1);
    cyc("bp.match", 0, 0, 0, 10'h155, 4'h5, 0);
    for (int i = 0; i < 3; i++) cyc("bp.stall", 0, 0, 0, 10'h000, 4'h0, 0);
    chk("bp.noovf", overflow, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("bp.idx%0d", i), rec_data[17:14], i + 2);
      cyc("bp.drain", 0, 0, 0, 10'h000, 4'h0, 1);
    end

    // Start while SETTLING is ignored: stim_q stays 1.
    cyc("ign", 0, 1, 1, 10'h000, 4'h0, 1);
    cyc("ign", 0, 1, 0, 10'h000, 4'h0, 1);
    cyc("ign", 0, 1, 0, 10'h000, 4'h0, 1);
    cyc("ign", 0, 1, 0, 10'h155, 4'h5, 1);
    chk("ign.settle2", settle_cycles, 32'd2);
    chk("ign.pass",    pass,          32'd1);

    // Overflow then re-arm from PASS clears FIFO and overflow.
    cyc("rearm", 0, 1, 0, 10'h000, 4'h0, 0);
    for (int i = 0; i < 5; i++) cyc("rearm", 0, 0, 0, 10'h000, 4'h0, 0);
    cyc("rearm", 0, 0, 0, 10'h2AA, 4'hA, 0);
    chk("rearm.ovf1", overflow, 32'd1);
    cyc("rearm", 0, 1, 1, 10'h000, 4'h0, 0);
    chk("rearm.ovf0",   overflow,  32'd0);
    chk("rearm.valid0", rec_valid, 32'd0);

    // Reset at idx=2 aborts without done; rst wins over start.
    cyc("rst", 0, 0, 0, 10'h000, 4'h0, 0);
    cyc("rst", 0, 0, 0, 10'h000, 4'h0, 0);
    cyc("rst", 1, 1, 1, 10'h000, 4'h0, 0);
    chk("rst.busy",   busy,          32'd0);
    chk("rst.done",   done,          32'd0);
    chk("rst.valid",  rec_valid,     32'd0);
    chk("rst.settle", settle_cycles, 32'd0);
    cyc("rst.idle", 0, 0, 0, 10'h155, 4'h5, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, st, rdy;
      logic [9:0]  v;
      logic [3:0]  n;
      r   = ($urandom_range(0, 63) == 0);
      s   = ($urandom_range(0, 7) == 0);
      st  = 1'($urandom);
      rdy = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        v = m_stim ? 10'h155 : 10'h2AA;
        n = m_stim ? 4'h5 : 4'hA;
      end else begin
        v = 10'($urandom);
        n = 4'($urandom);
      end
      cyc("rnd", r, s, st, v, n, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
